// File: rtl/fifo_pkg.sv
// fifo_pkg: depth/level helpers and status-bit indices shared by the FIFO family.
package fifo_pkg;

  localparam int STAT_EMPTY     = 0;
  localparam int STAT_AEMPTY    = 1;
  localparam int STAT_AFULL     = 2;
  localparam int STAT_FULL      = 3;
  localparam int STAT_OVERFLOW  = 4;
  localparam int STAT_UNDERFLOW = 5;
  localparam int STAT_W         = 6;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  function automatic int depth_of(input int addr_width);
    return 1 << addr_width;
  endfunction

  function automatic int default_af(input int addr_width);
    return depth_of(addr_width) - 4;
  endfunction

  function automatic int default_ae();
    return 4;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// fifo_ram: simple dual-port RAM, one write port and one registered read port with enable.
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 72,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  i_wr_en,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic                  i_rd_en,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  output logic [DATA_WIDTH-1:0] o_rd_data
);

  localparam int DEPTH = depth_of(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];
  logic [DATA_WIDTH-1:0] r_rd_data;

  // NOTE: the array and its read register carry no reset so they map onto block RAM;
  // the parent's valid flag qualifies o_rd_data.
  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/fifo_fwft.sv
// fifo_fwft: first-word-fall-through FIFO, registered-read RAM plus a 2-entry prefetch stage.
// Optional FIFO_STATS_EN adds the hwm (high-water mark of count) output.
module fifo_fwft
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 72,
  parameter int ADDR_WIDTH = 9,
  parameter int AF_LEVEL   = default_af(ADDR_WIDTH),
  parameter int AE_LEVEL   = default_ae()
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  wr_en,
  output logic                  full,
  output logic                  almost_full,
  output logic [DATA_WIDTH-1:0] dout,
  input  logic                  rd_en,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
`ifdef FIFO_STATS_EN
  ,
  output logic [ADDR_WIDTH:0]   hwm
`endif
);

  localparam int                DEPTH   = depth_of(ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH+1)'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH+1)'(AE_LEVEL);

  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic [DATA_WIDTH-1:0] r_dout;
  logic [DATA_WIDTH-1:0] r_skid;
  logic                  r_out_valid;
  logic                  r_skid_valid;
  logic                  r_ram_valid;
  logic                  r_overflow;
  logic                  r_underflow;

  logic [DATA_WIDTH-1:0] w_ram_rdata;
  logic                  w_full;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_rd_issue;
  logic [1:0]            w_stage_cnt;
  logic [1:0]            w_stage_next;
  logic [STAT_W-1:0]     w_status;

  // A RAM read is issued only when the prefetch stage is certain to have room for
  // the word one cycle later, so read data never has to be held back.
  always_comb begin
    w_full       = (r_count == DEPTH_C);
    w_push       = wr_en && !w_full && !clr;
    w_pop        = rd_en && r_out_valid && !clr;
    w_stage_cnt  = 2'(r_out_valid) + 2'(r_skid_valid) + 2'(r_ram_valid);
    w_stage_next = w_stage_cnt - 2'(w_pop);
    w_rd_issue   = !clr && (r_count > (ADDR_WIDTH+1)'(w_stage_cnt)) && (w_stage_next < 2'd2);
  end

  fifo_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk       (clk),
    .i_wr_en   (w_push),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (din),
    .i_rd_en   (w_rd_issue),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (w_ram_rdata)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_dout       <= '0;
      r_skid       <= '0;
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
      r_ram_valid  <= 1'b0;
      r_overflow   <= 1'b0;
      r_underflow  <= 1'b0;
    end else if (clr) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_dout       <= '0;
      r_skid       <= '0;
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
      r_ram_valid  <= 1'b0;
      r_overflow   <= 1'b0;
      r_underflow  <= 1'b0;
    end else begin
      if (w_push)     r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_issue) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_ram_valid <= w_rd_issue;

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase

      if (wr_en && w_full)      r_overflow  <= 1'b1;
      if (rd_en && !r_out_valid) r_underflow <= 1'b1;

      // Head register refills from the skid entry first, then from RAM read data.
      if (w_pop) begin
        if (r_skid_valid) begin
          r_dout       <= r_skid;
          r_skid_valid <= r_ram_valid;
          if (r_ram_valid) r_skid <= w_ram_rdata;
        end else if (r_ram_valid) begin
          r_dout <= w_ram_rdata;
        end else begin
          r_out_valid <= 1'b0;
        end
      end else if (r_ram_valid) begin
        if (!r_out_valid) begin
          r_dout      <= w_ram_rdata;
          r_out_valid <= 1'b1;
        end else begin
          r_skid       <= w_ram_rdata;
          r_skid_valid <= 1'b1;
        end
      end
    end
  end

  // NOTE: every bit gets a default first so the combinational block cannot infer a latch.
  always_comb begin
    w_status                 = '0;
    w_status[STAT_EMPTY]     = !r_out_valid;
    w_status[STAT_AEMPTY]    = (r_count <= AE_C);
    w_status[STAT_AFULL]     = (r_count >= AF_C);
    w_status[STAT_FULL]      = w_full;
    w_status[STAT_OVERFLOW]  = r_overflow;
    w_status[STAT_UNDERFLOW] = r_underflow;
  end

  assign empty        = w_status[STAT_EMPTY];
  assign almost_empty = w_status[STAT_AEMPTY];
  assign almost_full  = w_status[STAT_AFULL];
  assign full         = w_status[STAT_FULL];
  assign overflow     = w_status[STAT_OVERFLOW];
  assign underflow    = w_status[STAT_UNDERFLOW];
  assign dout         = r_dout;
  assign count        = r_count;

`ifdef FIFO_STATS_EN
  logic [ADDR_WIDTH:0] r_hwm;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hwm <= '0;
    end else if (clr) begin
      r_hwm <= '0;
    end else if (r_count > r_hwm) begin
      r_hwm <= r_count;
    end
  end

  assign hwm = r_hwm;
`endif

endmodule

// File: tb/tb_fifo_fwft.sv
// tb_fifo_fwft: directed and randomized stimulus against a queue-based model of the FWFT FIFO.
module tb_fifo_fwft;

  localparam int DW    = 72;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int AF_M  = 12;
  localparam int AE_M  = 4;

  logic          clk;
  logic          rst_n;
  logic          clr;
  logic [DW-1:0] din;
  logic          wr_en;
  logic          rd_en;
  logic          full;
  logic          almost_full;
  logic [DW-1:0] dout;
  logic          empty;
  logic          almost_empty;
  logic [AW:0]   count;
  logic          overflow;
  logic          underflow;
`ifdef FIFO_STATS_EN
  logic [AW:0]   hwm;
`endif

  fifo_fwft #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr          (clr),
    .din          (din),
    .wr_en        (wr_en),
    .full         (full),
    .almost_full  (almost_full),
    .dout         (dout),
    .rd_en        (rd_en),
    .empty        (empty),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
`ifdef FIFO_STATS_EN
    ,
    .hwm          (hwm)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  bit chk_on  = 1'b0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // Reference model: ordered list of stored words, each with the edge after which
  // it may be presented (write edge + 2).
  typedef struct {
    logic [DW-1:0] data;
    int            ready;
  } ent_t;

  ent_t          q[$];
  int            cyc   = 0;
  logic [DW-1:0] m_dout = '0;
  bit            m_ovf = 1'b0;
  bit            m_udf = 1'b0;
  int            m_hwm = 0;

  function automatic void model_clear();
    q.delete();
    m_dout = '0;
    m_ovf  = 1'b0;
    m_udf  = 1'b0;
    m_hwm  = 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_clear();
    end else begin
      bit vis;
      int n;
      n   = q.size();
      vis = (n > 0) && (q[0].ready <= cyc);
      cyc++;
      if (clr) begin
        model_clear();
      end else begin
        if (wr_en && n == DEPTH) m_ovf = 1'b1;
        if (rd_en && !vis)       m_udf = 1'b1;
        if (n > m_hwm)           m_hwm = n;
        if (rd_en && vis)        void'(q.pop_front());
        if (wr_en && n < DEPTH)  q.push_back('{data: din, ready: cyc + 2});
        if (q.size() > 0 && q[0].ready <= cyc) m_dout = q[0].data;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      int n;
      bit vis;
      n   = q.size();
      vis = (n > 0) && (q[0].ready <= cyc);
      check("count", count, n);
      check("empty", empty, !vis);
      check("full", full, n == DEPTH);
      check("almost_full", almost_full, n >= AF_M);
      check("almost_empty", almost_empty, n <= AE_M);
      check("overflow", overflow, m_ovf);
      check("underflow", underflow, m_udf);
      check("dout", dout, m_dout);
`ifdef FIFO_STATS_EN
      check("hwm", hwm, m_hwm);
`endif
    end
  end

  task automatic drive(input logic w, input logic r, input logic [DW-1:0] d, input logic c = 1'b0);
    wr_en = w;
    rd_en = r;
    din   = d;
    clr   = c;
    @(negedge clk);
  endtask

  function automatic logic [DW-1:0] rand_word();
    logic [95:0] t;
    t = {$urandom, $urandom, $urandom};
    return t[DW-1:0];
  endfunction

  initial begin
    rst_n = 1'b1;
    clr   = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    din   = '0;
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk_on = 1'b1;

    // Reset held while wr_en toggles
    for (int i = 0; i < 4; i++) drive(i[0] ? 1'b0 : 1'b1, 1'b0, DW'(i + 1));
    check("rst_empty", empty, 1);
    check("rst_count", count, 0);
    check("rst_ovf", overflow, 0);
    rst_n = 1'b1;
    drive(1'b0, 1'b0, '0);
    drive(1'b0, 1'b0, '0);
    check("rel_count", count, 0);
    check("rel_udf", underflow, 0);

    // Latency: A5 written at edge N is presented after edge N+2
    drive(1'b1, 1'b0, DW'('hA5));
    check("lat_n_empty", empty, 1);
    drive(1'b0, 1'b0, '0);
    check("lat_n1_empty", empty, 1);
    drive(1'b0, 1'b0, '0);
    check("lat_n2_empty", empty, 0);
    check("lat_n2_dout", dout, DW'('hA5));
    drive(1'b0, 1'b1, '0);
    check("lat_pop_empty", empty, 1);
    check("lat_pop_count", count, 0);

    // Fill to capacity
    for (int i = 1; i <= 17; i++) begin
      drive(1'b1, 1'b0, DW'(i));
      if (i == 4)  check("fill_ae4", almost_empty, 1);
      if (i == 5)  check("fill_ae5", almost_empty, 0);
      if (i == 11) check("fill_af11", almost_full, 0);
      if (i == 12) check("fill_af12", almost_full, 1);
      if (i == 15) check("fill_full15", full, 0);
      if (i == 16) check("fill_full16", full, 1);
    end
    check("fill_ovf", overflow, 1);
    check("fill_count", count, 16);
    check("mdl_cnt16", q.size(), 16);
    check("fill_head", dout, DW'(1));

    // Underflow on empty, then write+pop while empty
    drive(1'b0, 1'b0, '0, 1'b1);
    check("clr_ovf", overflow, 0);
    check("clr_count", count, 0);
    drive(1'b0, 1'b1, '0);
    check("udf_set", underflow, 1);
    check("udf_count", count, 0);
    drive(1'b1, 1'b1, DW'('h77));
    check("wrpop_empty_cnt", count, 1);

    // Write+pop while full
    drive(1'b0, 1'b0, '0, 1'b1);
    for (int i = 0; i < 16; i++) drive(1'b1, 1'b0, DW'(100 + i));
    drive(1'b0, 1'b0, '0);
    drive(1'b1, 1'b1, DW'('hEE));
    check("wrpop_full_cnt", count, 15);
    check("wrpop_full_ovf", overflow, 1);
    check("wrpop_full_dout", dout, DW'(101));
    for (int i = 0; i < 15; i++) drive(1'b0, 1'b1, '0);
    check("drain_count", count, 0);
    check("drain_empty", empty, 1);
    check("drain_hold", dout, DW'(115));

    // Streaming: three words primed, then write+pop every cycle
    drive(1'b0, 1'b0, '0, 1'b1);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, DW'(i));
    drive(1'b0, 1'b0, '0);
    drive(1'b0, 1'b0, '0);
    for (int i = 0; i < 1000; i++) begin
      drive(1'b1, 1'b1, DW'(3 + i));
      if (i % 100 == 0) check("stream_dout", dout, DW'(i + 1));
    end
    check("stream_count", count, 3);
    check("stream_udf", underflow, 0);

    // clr mid-stream
    drive(1'b1, 1'b1, DW'('h55), 1'b1);
    check("mclr_count", count, 0);
    check("mclr_empty", empty, 1);
    check("mclr_ae", almost_empty, 1);
    check("mclr_dout", dout, 0);

`ifdef FIFO_STATS_EN
    for (int i = 0; i < 9; i++) drive(1'b1, 1'b0, DW'(i));
    drive(1'b0, 1'b0, '0);
    drive(1'b0, 1'b0, '0);
    for (int i = 0; i < 9; i++) drive(1'b0, 1'b1, '0);
    drive(1'b0, 1'b0, '0);
    check("hwm_nine", hwm, 9);
    check("hwm_drained", count, 0);
    drive(1'b0, 1'b0, '0, 1'b1);
    check("hwm_clr", hwm, 0);
`endif

    // Randomized phases biased toward filling, draining and balanced traffic
    for (int ph = 0; ph < 6; ph++) begin
      int unsigned wp;
      wp = (ph % 3 == 0) ? 80 : ((ph % 3 == 1) ? 20 : 50);
      for (int c = 0; c < 500; c++) begin
        drive($urandom_range(99) < wp, $urandom_range(99) < (100 - wp), rand_word(),
              $urandom_range(299) == 0);
      end
    end

    drive(1'b0, 1'b0, '0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
